// File: rtl/quiz_pkg.sv
// Shared types and default sizing for the quiz round controller.
package quiz_pkg;

  typedef logic [1:0] ans_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_SHOW     = 3'd2,
    ST_WAIT_ANS = 3'd3,
    ST_JUDGE    = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } quiz_state_e;

  localparam int DEF_NUM_Q       = 10;
  localparam int DEF_SHOW_CYC    = 50;
  localparam int DEF_ANS_TIMEOUT = 1000;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire is flagged while enabled and the count has reached zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/quiz_round_controller.sv
// Sequences a quiz game: show each question, collect or time out an answer, judge it.
module quiz_round_controller
  import quiz_pkg::*;
#(
  parameter int NUM_Q       = DEF_NUM_Q,
  parameter int SHOW_CYC    = DEF_SHOW_CYC,
  parameter int ANS_TIMEOUT = DEF_ANS_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_ans_valid,
  input  ans_t                     i_ans_data,
  output logic                     o_ans_ready,
  input  ans_t                     i_key_data,
  output logic [$clog2(NUM_Q)-1:0] o_q_idx,
  output logic                     o_q_show,
  output logic                     o_score_clr,
  output logic                     o_correct,
  output logic                     o_wrong,
  output logic                     o_timeout,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int QW      = $clog2(NUM_Q);
  localparam int MAX_CYC = (SHOW_CYC > ANS_TIMEOUT) ? SHOW_CYC : ANS_TIMEOUT;
  localparam int TW      = $clog2(MAX_CYC + 1);

  quiz_state_e   r_state;
  quiz_state_e   w_state_next;
  logic [QW-1:0] r_q_idx;
  ans_t          r_cap;
  logic          r_match;
  logic          r_timeout;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_en;
  logic          w_tmr_exp;
  logic          w_handshake;
  logic          w_last_q;

  assign w_handshake = (r_state == ST_WAIT_ANS) && i_ans_valid;
  assign w_last_q    = (r_q_idx == QW'(NUM_Q - 1));

  // The timer is reloaded on every transition into SHOW or WAIT_ANS.
  // WAIT_ANS loads ANS_TIMEOUT-2 so the registered timeout lands ANS_TIMEOUT-1 cycles after entry.
  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_en     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) w_state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_state_next = ST_SHOW;
        w_tmr_load   = 1'b1;
        w_tmr_val    = TW'(SHOW_CYC - 1);
      end
      ST_SHOW: begin
        w_tmr_en = 1'b1;
        if (w_tmr_exp) begin
          w_state_next = ST_WAIT_ANS;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(ANS_TIMEOUT - 2);
        end
      end
      ST_WAIT_ANS: begin
        w_tmr_en = 1'b1;
        if (w_handshake)    w_state_next = ST_JUDGE;
        else if (w_tmr_exp) w_state_next = ST_NEXT;
      end
      ST_JUDGE: begin
        w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (w_last_q) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SHOW;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(SHOW_CYC - 1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_expire   (w_tmr_exp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_q_idx   <= '0;
      r_cap     <= '0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= (r_state == ST_WAIT_ANS) && !i_ans_valid && w_tmr_exp;
      if (r_state == ST_CLEAR) begin
        r_q_idx <= '0;
      end else if ((r_state == ST_NEXT) && !w_last_q) begin
        r_q_idx <= r_q_idx + 1'b1;
      end
      // Key comparison is captured with the answer so the verdict is a pure register decode.
      if (w_handshake) begin
        r_cap   <= i_ans_data;
        r_match <= (i_ans_data == i_key_data);
      end
    end
  end

  assign o_ans_ready = (r_state == ST_WAIT_ANS);
  assign o_q_show    = (r_state == ST_SHOW);
  assign o_score_clr = (r_state == ST_CLEAR);
  assign o_correct   = (r_state == ST_JUDGE) && r_match;
  assign o_wrong     = (r_state == ST_JUDGE) && !r_match;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done      = (r_state == ST_DONE);
  assign o_q_idx     = r_q_idx;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller with a +5 score counter attached.
module tb_quiz_round_controller;
  import quiz_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ans_valid = 1'b0;
  ans_t       ans_data = '0;
  ans_t       key_data;
  logic       ans_ready;
  logic [1:0] q_idx;
  logic       q_show, score_clr, correct, wrong, timeout, busy, done;
  int         score;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  quiz_round_controller #(
    .NUM_Q       (3),
    .SHOW_CYC    (4),
    .ANS_TIMEOUT (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_ans_valid (ans_valid),
    .i_ans_data  (ans_data),
    .o_ans_ready (ans_ready),
    .i_key_data  (key_data),
    .o_q_idx     (q_idx),
    .o_q_show    (q_show),
    .o_score_clr (score_clr),
    .o_correct   (correct),
    .o_wrong     (wrong),
    .o_timeout   (timeout),
    .o_busy      (busy),
    .o_done      (done)
  );

  function automatic ans_t key_of(input logic [1:0] q);
    case (q)
      2'd0:    return 2'd2;
      2'd1:    return 2'd0;
      default: return 2'd3;
    endcase
  endfunction

  assign key_data = key_of(q_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         score <= 0;
    else if (score_clr) score <= 0;
    else if (correct)   score <= score + 5;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_clr"}, score_clr, 1);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Returns in the first WAIT_ANS cycle after checking the show window length.
  task automatic to_wait(input string tag, input int exp_q);
    int guard = 0;
    int n = 0;
    while (!q_show && guard < 40) begin tick(); guard++; end
    while (q_show && n < 40) begin tick(); n++; end
    check({tag, "_show_len"}, n, 4);
    check({tag, "_ready"}, ans_ready, 1);
    check({tag, "_qidx"}, q_idx, exp_q);
  endtask

  task automatic answer(input string tag, input ans_t a, input int delay, input bit exp_ok);
    repeat (delay) tick();
    check({tag, "_ready_hs"}, ans_ready, 1);
    ans_valid = 1'b1;
    ans_data  = a;
    tick();
    ans_valid = 1'b0;
    ans_data  = '0;
    check({tag, "_correct"}, correct, int'(exp_ok));
    check({tag, "_wrong"}, wrong, int'(!exp_ok));
    check({tag, "_timeout"}, timeout, 0);
    tick();
    check({tag, "_pulse_len"}, int'(correct) + int'(wrong) + int'(timeout), 0);
    $display("%s: answered %0d after %0d cycles, correct=%0b score=%0d", tag, a, delay, exp_ok, score);
  endtask

  task automatic expect_timeout(input string tag);
    repeat (6) tick();
    check({tag, "_ready_c6"}, ans_ready, 1);
    check({tag, "_to_c6"}, timeout, 0);
    tick();
    check({tag, "_to_c7"}, timeout, 1);
    check({tag, "_ready_c7"}, ans_ready, 0);
    check({tag, "_excl_c7"}, int'(correct) + int'(wrong), 0);
    tick();
    check({tag, "_to_c8"}, timeout, 0);
    $display("%s: timed out, score=%0d", tag, score);
  endtask

  task automatic expect_done(input string tag, input int exp_score);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_qidx"}, q_idx, 2);
    check({tag, "_score"}, score, exp_score);
    $display("%s: game over, score=%0d", tag, score);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ready", ans_ready, 0);
    check("rst_qidx", q_idx, 0);
    check("rst_pulses", int'(q_show) + int'(score_clr) + int'(correct) + int'(wrong) + int'(timeout), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    check("idle_hold", busy, 0);

    // All-correct game.
    pulse_start("g1_start");
    to_wait("g1_q0", 0);
    answer("g1_q0", 2'd2, 2, 1'b1);
    to_wait("g1_q1", 1);
    answer("g1_q1", 2'd0, 0, 1'b1);
    to_wait("g1_q2", 2);
    answer("g1_q2", 2'd3, 3, 1'b1);
    expect_done("g1", 15);

    // Restart from DONE, wrong answer on q0.
    pulse_start("g2_start");
    tick();
    check("g2_score_cleared", score, 0);
    to_wait("g2_q0", 0);
    answer("g2_q0", 2'd1, 1, 1'b0);
    check("g2_score_after_wrong", score, 0);
    to_wait("g2_q1", 1);
    answer("g2_q1", 2'd0, 2, 1'b1);
    to_wait("g2_q2", 2);
    answer("g2_q2", 2'd3, 2, 1'b1);
    expect_done("g2", 10);

    // Timeout on q0, handshake racing expiry on q1.
    pulse_start("g3_start");
    to_wait("g3_q0", 0);
    expect_timeout("g3_q0");
    check("g3_score_after_to", score, 0);
    check("g3_qidx_after_to", q_idx, 1);
    to_wait("g3_q1", 1);
    answer("g3_q1_race", 2'd0, 6, 1'b1);
    to_wait("g3_q2", 2);
    answer("g3_q2", 2'd3, 0, 1'b1);
    expect_done("g3", 10);

    // Start while busy is ignored; asynchronous reset mid-game.
    pulse_start("g4_start");
    to_wait("g4_q0", 0);
    answer("g4_q0", 2'd2, 0, 1'b1);
    to_wait("g4_q1", 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g4_busy_start_clr", score_clr, 0);
    check("g4_busy_start_ready", ans_ready, 1);
    check("g4_busy_start_score", score, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("g4_arst_ready", ans_ready, 0);
    check("g4_arst_busy", busy, 0);
    check("g4_arst_qidx", q_idx, 0);
    check("g4_arst_pulses", int'(q_show) + int'(score_clr) + int'(correct) + int'(wrong) + int'(timeout) + int'(done), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("g4_idle_after_rst", busy, 0);
    check("g4_done_after_rst", done, 0);
    $display("g4: reset mid-game, busy=%0b", busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quiz_round_controller.md
QUIZ_ROUND_CONTROLLER -- requirements
Module: quiz_round_controller

Interface
REQ-001 Parameter NUM_Q, default 10, number of questions per game.
REQ-002 Parameter SHOW_CYC, default 50, cycles each question is displayed before answers open.
REQ-003 Parameter ANS_TIMEOUT, default 1000, cycles allowed for an answer.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin game; sampled only in IDLE or DONE.
REQ-007 ans_valid  input  1  answer offered.
REQ-008 ans_data  input  2  answer choice A..D.
REQ-009 ans_ready  output  1  high only in WAIT_ANS.
REQ-010 key_data  input  2  correct choice for question q_idx; stable while q_idx is stable.
REQ-011 q_idx  output  $clog2(NUM_Q)  current question index.
REQ-012 q_show  output  1  high in SHOW.
REQ-013 score_clr  output  1  one-cycle clear pulse to the score counter.
REQ-014 correct  output  1  one-cycle pulse; the score counter adds 5 per pulse.
REQ-015 wrong  output  1  one-cycle pulse on a mismatched answer.
REQ-016 timeout  output  1  one-cycle pulse when no answer arrives in time.
REQ-017 busy  output  1  high in every state except IDLE and DONE.
REQ-018 done  output  1  held high in DONE.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, SHOW, WAIT_ANS, JUDGE, NEXT and DONE.
REQ-020 IDLE: start=1 -> CLEAR.
REQ-021 CLEAR: lasts 1 cycle; asserts score_clr; sets q_idx=0 -> SHOW.
REQ-022 SHOW: lasts exactly SHOW_CYC cycles; asserts q_show -> WAIT_ANS.
REQ-023 WAIT_ANS: the answer timer reloads on entry.
- ans_valid&&ans_ready in cycle t captures ans_data -> JUDGE.
- No handshake within ANS_TIMEOUT cycles -> timeout pulse in cycle ANS_TIMEOUT-1 after entry -> NEXT.
REQ-024 Handshake and timer expiry in the same cycle: the handshake SHALL win and timeout SHALL stay low.
REQ-025 JUDGE: lasts 1 cycle (cycle t+1); asserts correct if captured==key_data, otherwise wrong -> NEXT.
REQ-026 NEXT: lasts 1 cycle.
- q_idx==NUM_Q-1 -> DONE.
- Otherwise q_idx+1 -> SHOW.
- q_idx SHALL never wrap.
REQ-027 DONE: holds done=1 and q_idx; start=1 -> CLEAR (restart).
REQ-028 start SHALL be ignored while busy=1; ans_valid SHALL be ignored when ans_ready=0.
REQ-029 Per question, exactly one of correct/wrong/timeout SHALL pulse; the pulses are mutually exclusive in every cycle.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 SHALL force IDLE immediately, from any state, including mid-game.
REQ-032 Reset values: all outputs 0, q_idx=0, timers 0, captured answer 0.

Structure
REQ-033 Package quiz_pkg SHALL hold the state enum type, ans_t (2-bit typedef), and the default constants for NUM_Q, SHOW_CYC and ANS_TIMEOUT.
REQ-034 One sub-module, cycle_timer, SHALL provide the count: load, enable and expire outputs, parameterised width.
- It is instantiated once and shared by SHOW and WAIT_ANS.

Verification
Parameters for all scenarios: NUM_Q=3, SHOW_CYC=4, ANS_TIMEOUT=8, score counter attached.
REQ-035 Correct game: start, then answer ans_data=key_data for all 3 questions -> 3 correct pulses, each 1 cycle after its handshake; done=1; score=15.
REQ-036 Wrong answer: q0 key=2, ans=1 -> wrong pulse, no correct pulse, q_idx=1 after NEXT; final score=10 if q1 and q2 are answered correctly.
REQ-037 Timeout: no ans_valid on q0 -> timeout pulse 7 cycles after entering WAIT_ANS; q_idx=1; score unchanged.
REQ-038 Race: ans_valid with correct data in the expiry cycle -> correct pulse, timeout=0.
REQ-039 Reset mid-game: rst_n low during WAIT_ANS of q_idx=1 -> all outputs 0 asynchronously, IDLE; a start pulse while busy has no effect.
REQ-040 Restart: start in DONE -> score_clr pulse, score=0, q_idx=0, q_show high for 4 cycles.
